// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch stage and the
// memory stage. Requests are arbitrated from IDLE, the winner's request
// is latched onto the bus, and the transfer ends on bus_ack or on a wait
// timeout. A one-cycle DONE state delivers the winner's ready pulse.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch stage
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  // memory stage
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  // shared memory port
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  // pipeline control
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUS  = 2'd1,
    MEM_BUS = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  // Last value of the wait counter before the transfer is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              bus_err_q, bus_err_d;

  logic              mem_wins;
  logic              in_bus;
  logic              timed_out;
  logic              bus_done;

  // Arbitration decision and end-of-transfer conditions.
  always_comb begin
    // On contention the side not granted last wins; alone, a requester wins.
    mem_wins  = mem_req & (~if_req | (last_grant_q == GNT_IF));
    // bus_req is high exactly while in a BUS state, so an ack outside
    // these states never reaches the FSM.
    in_bus    = (state_q == IF_BUS) || (state_q == MEM_BUS);
    timed_out = in_bus & ~bus_ack & (wait_cnt_q == WAIT_LAST);
    bus_done  = in_bus & (bus_ack | timed_out);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_wins) begin
          state_d = MEM_BUS;
        end else if (if_req) begin
          state_d = IF_BUS;
        end
      end
      IF_BUS, MEM_BUS: begin
        if (bus_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Requests seen here are stale; they are re-arbitrated from IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    bus_err_d    = bus_err_q;

    case (state_q)
      IDLE: begin
        if (mem_wins) begin
          last_grant_d = GNT_MEM;
          wait_cnt_d   = 8'd0;
          bus_req_d    = 1'b1;
          bus_we_d     = mem_we;
          bus_addr_d   = mem_addr;
          bus_wdata_d  = mem_wdata;
        end else if (if_req) begin
          last_grant_d = GNT_IF;
          wait_cnt_d   = 8'd0;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_addr_d   = if_addr;
          bus_wdata_d  = '0;
        end
      end
      IF_BUS: begin
        if (bus_done) begin
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = timed_out ? '0 : bus_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      MEM_BUS: begin
        if (bus_done) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          mem_ready_d = 1'b1;
          // A store never disturbs the load-data register.
          if (!bus_we_q) begin
            mem_rdata_d = timed_out ? '0 : bus_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
      end
    endcase

    if (timed_out) begin
      bus_err_d = 1'b1;
    end
  end

  // Registered outputs and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_IF;
      wait_cnt_q   <= 8'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;

  // Stalls are combinational so the pipeline releases in the ready cycle.
  assign stall_mem = mem_req & ~mem_ready_q;
  assign stall_if  = (if_req & ~if_ready_q) | stall_mem;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic          stall_if, stall_mem, bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  // Transaction model: one outstanding transfer, a one-cycle completion
  // slot, arbitration history and the two read-data holders.
  bit            m_act, m_done, m_own, m_we, m_last, m_err, m_ifr, m_memr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rd, m_mem_rd;
  int            m_wait, m_lat;
  int            lat_next = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 50;
    return $urandom_range(0, 3);
  endfunction

  task automatic model_reset();
    m_act = 0; m_done = 0; m_own = 0; m_we = 0; m_last = 0; m_err = 0;
    m_ifr = 0; m_memr = 0; m_addr = '0; m_wdata = '0;
    m_if_rd = '0; m_mem_rd = '0; m_wait = 0; m_lat = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [DW-1:0] v;
    m_ifr = 0;
    m_memr = 0;
    if (m_done) begin
      m_done = 0;
    end else if (!m_act) begin
      if (if_req || mem_req) begin
        m_own  = (if_req && mem_req) ? ~m_last : mem_req;
        m_last = m_own;
        m_act  = 1;
        m_wait = 0;
        m_lat  = (lat_next >= 0) ? lat_next : pick_lat();
        if (m_own) begin
          m_addr = mem_addr; m_wdata = mem_wdata; m_we = mem_we;
        end else begin
          m_addr = if_addr; m_wdata = '0; m_we = 0;
        end
      end
    end else if (bus_ack || m_wait == TO - 1) begin
      v = bus_ack ? bus_rdata : '0;
      if (!bus_ack) m_err = 1;
      m_act  = 0;
      m_done = 1;
      if (m_own) begin
        m_memr = 1;
        if (!m_we) m_mem_rd = v;
      end else begin
        m_ifr = 1;
        m_if_rd = v;
      end
    end else begin
      m_wait++;
    end
  endtask

  task automatic compare_regs();
    chk("bus_req", bus_req, m_act);
    if (m_act) begin
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_we", bus_we, m_we);
      if (m_own) chk("bus_wdata", bus_wdata, m_wdata);
    end
    chk("if_ready", if_ready, m_ifr);
    chk("mem_ready", mem_ready, m_memr);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("mem_rdata", mem_rdata, m_mem_rd);
    chk("bus_err", bus_err, m_err);
  endtask

  task automatic compare_stalls();
    bit sm;
    sm = mem_req & ~m_memr;
    chk("stall_mem", stall_mem, sm);
    chk("stall_if", stall_if, (if_req & ~m_ifr) | sm);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_bus_we"}, bus_we, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_if_ready"}, if_ready, 0);
    chk({tag, "_mem_ready"}, mem_ready, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
    chk({tag, "_bus_err"}, bus_err, 0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk_all_zero(tag);
    if_req = 0; mem_req = 0; bus_ack = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic cycle(input bit ir, input logic [AW-1:0] ia, input bit mr, input bit mw,
                       input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic [DW-1:0] rd);
    @(negedge clk);
    if_req = ir; if_addr = ia; mem_req = mr; mem_we = mw;
    mem_addr = ma; mem_wdata = md; bus_rdata = rd;
    bus_ack = m_act ? (m_wait == m_lat) : ($urandom_range(0, 3) == 0);
    #1 compare_stalls();
    @(posedge clk);
    model_step();
    #1 compare_regs();
  endtask

  task automatic idle_cycle();
    cycle(0, '0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, cnt, mem_seen_at, gap;
    bit  got, if_seen, if_started, mem_first;

    rst_n = 1'b0; if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0;
    mem_addr = '0; mem_wdata = '0; bus_ack = 0; bus_rdata = '0;
    model_reset();
    #3 chk_all_zero("reset0");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Fetch with ack two cycles into the bus request.
    lat_next = 2; n = 0; got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      cycle(1, 32'h100, 0, 0, '0, '0, 32'h2402000A);
      n++;
      if (if_ready) begin
        got = 1;
        chk("A_if_rdata_lit", if_rdata, 32'h2402000A);
        chk("A_latency_lit", n, 4);
      end else begin
        chk("A_stall_if_lit", stall_if, 1);
      end
    end
    chk("A_ready_seen", got, 1);
    idle_cycle();

    // Contention right after reset: MEM first, stale MEM request across DONE ignored.
    do_reset("resetB");
    lat_next = 0; mem_seen_at = -1; if_seen = 0; if_started = 0; gap = 0; mem_first = 0;
    for (int i = 0; i < 20 && !if_seen; i++) begin
      cycle(1, 32'h300, (mem_seen_at < 0) || (i == mem_seen_at + 1), 0, 32'h200,
            32'h0, 32'h11112222);
      if (i == 0) chk("B_first_addr_lit", bus_addr, 32'h200);
      if (mem_seen_at >= 0 && i > mem_seen_at && !if_started) begin
        if (bus_req) begin
          if_started = 1;
          chk("B_gap_lit", gap, 1);
          chk("B_second_addr_lit", bus_addr, 32'h300);
        end else begin
          gap++;
        end
      end
      if (mem_ready) begin
        mem_seen_at = i;
        mem_first = !if_seen;
      end
      if (if_ready) if_seen = 1;
    end
    chk("B_mem_first_lit", mem_first, 1);
    chk("B_if_seen", if_seen, 1);
    idle_cycle();

    // Store acked in its first bus cycle; load data must survive.
    n = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(0, '0, 1, 1, 32'h40, 32'hDEADBEEF, 32'h55555555);
      n++;
      if (n == 1) begin
        chk("C_bus_we_lit", bus_we, 1);
        chk("C_bus_addr_lit", bus_addr, 32'h40);
        chk("C_bus_wdata_lit", bus_wdata, 32'hDEADBEEF);
      end
      if (mem_ready) begin
        got = 1;
        chk("C_latency_lit", n, 2);
        chk("C_mem_rdata_lit", mem_rdata, 32'h11112222);
      end
    end
    chk("C_ready_seen", got, 1);
    idle_cycle();

    // No ack at all: timeout abort.
    lat_next = 50; cnt = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(1, 32'h500, 0, 0, '0, '0, 32'hFFFFFFFF);
      if (bus_req) cnt++;
      if (if_ready) begin
        got = 1;
        chk("D_bus_req_cycles_lit", cnt, 8);
        chk("D_if_rdata_lit", if_rdata, 0);
        chk("D_bus_err_lit", bus_err, 1);
      end
    end
    chk("D_ready_seen", got, 1);
    idle_cycle();
    idle_cycle();
    chk("D_bus_err_sticky_lit", bus_err, 1);

    // Reset while a load is on the bus.
    cnt = 0;
    for (int i = 0; i < 10 && cnt < 3; i++) begin
      cycle(0, '0, 1, 0, 32'h600, '0, 32'h12345678);
      if (bus_req) cnt++;
    end
    chk("F_bus_active", cnt, 3);
    do_reset("resetF");
    lat_next = -1;

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("resetR");
      end else begin
        cycle($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
